// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared ALU types: divider state codes, flag bundle, two's-complement helpers
package div_iter_pkg;

    // Divider FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

    // Condition flags reported with every result
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Widest operand the helpers below support
    localparam int MAX_W = 64;

    // Magnitude of a sign-extended value; the most negative value maps onto
    // itself, which is the correct unsigned magnitude once truncated
    function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring divider datapath, one quotient bit per step (DIV_ITER_REM_EN exposes the remainder)
module div_iter_core
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last_step,
`ifdef DIV_ITER_REM_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // Trial subtraction of the shifted partial remainder; the difference is
    // always smaller than the divisor when it fits, so WIDTH bits suffice
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = shifted >= {1'b0, dvs};
        diff    = shifted[WIDTH-1:0] - dvs;
    end

    // Partial remainder / dividend shift register and step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= CW'(WIDTH - 1);
        end else if (step) begin
            rem <= fits ? diff : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
            cnt <= cnt - CW'(1);
        end
    end

    assign last_step = (cnt == '0);
    assign quotient  = quo;
`ifdef DIV_ITER_REM_EN
    assign remainder = rem;
`endif

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - sequential signed/unsigned divider with flags and start/busy/done handshake (DIV_ITER_REM_EN enables remainder)
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    state_t           state;
    logic             neg_q;
    logic             dz_q;
    logic             ovf_q;
    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             core_last;
    flags_t           flags;
`ifdef DIV_ITER_REM_EN
    logic             neg_r;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] core_rem;
`endif

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        logic [MAX_W-1:0] m;
        m = twos_abs({{(MAX_W-WIDTH){x[WIDTH-1]}}, x});
        return m[WIDTH-1:0];
    endfunction

    // Operand magnitudes and request acceptance
    always_comb begin
        accept = (state == ST_IDLE) && start;
        b_zero = (b == '0);
        abs_a  = signed_mode ? abs_w(a) : a;
        abs_b  = signed_mode ? abs_w(b) : b;
    end

    div_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && !b_zero),
        .step      (state == ST_RUN),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .last_step (core_last),
`ifdef DIV_ITER_REM_EN
        .remainder (core_rem),
`endif
        .quotient  (core_quo)
    );

    // Sign correction of the unsigned result
    always_comb begin
        q_fix = neg_q ? (~core_quo + WIDTH'(1)) : core_quo;
`ifdef DIV_ITER_REM_EN
        r_fix = neg_r ? (~core_rem + WIDTH'(1)) : core_rem;
`else
        r_fix = '0;
`endif
        flags.z = (q_fix == '0);
        flags.n = q_fix[WIDTH-1];
        flags.c = (r_fix != '0);
        flags.v = ovf_q;
    end

    // Control FSM and capture of per-request attributes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            neg_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
`ifdef DIV_ITER_REM_EN
            neg_r <= 1'b0;
            a_q   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        neg_q <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                        dz_q  <= b_zero;
                        ovf_q <= signed_mode && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
`ifdef DIV_ITER_REM_EN
                        neg_r <= signed_mode && a[WIDTH-1];
                        a_q   <= a;
`endif
                        state <= b_zero ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_last) state <= ST_FIN;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result and flag registers, updated only on the done edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
        end else begin
            done <= (state == ST_FIN);
            if (state == ST_FIN) begin
                if (dz_q) begin
                    quotient  <= '0;
`ifdef DIV_ITER_REM_EN
                    remainder <= a_q;
`else
                    remainder <= '0;
`endif
                    dz <= 1'b1;
                    Z  <= 1'b0;
                    N  <= 1'b0;
                    C  <= 1'b0;
                    V  <= 1'b1;
                end else begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    dz <= 1'b0;
                    Z  <= flags.z;
                    N  <= flags.n;
                    C  <= flags.c;
                    V  <= flags.v;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - self-checking bench for div_iter against an arithmetic reference model
module tb_div_iter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;
    logic         Z;
    logic         N;
    logic         C;
    logic         V;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .dz          (dz),
        .Z           (Z),
        .N           (N),
        .C           (C),
        .V           (V)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the architectural rules
    task automatic model(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic [4:0] fl);
        int sx, sy, qi, ri;
        logic zf, nf, cf, vf, dzf;
        if (y == 0) begin
            q = '0; r = x; dzf = 1'b1; zf = 1'b0; nf = 1'b0; cf = 1'b0; vf = 1'b1;
`ifndef DIV_ITER_REM_EN
            r = '0;
`endif
        end else begin
            if (sm) begin
                sx = $signed(x);
                sy = $signed(y);
            end else begin
                sx = int'(x);
                sy = int'(y);
            end
            qi = sx / sy;
            ri = sx % sy;
            q = qi[W-1:0];
            r = ri[W-1:0];
            vf = (sm && sx == -32768 && sy == -1);
            dzf = 1'b0;
`ifndef DIV_ITER_REM_EN
            r = '0;
`endif
            zf = (q == 0);
            nf = q[W-1];
            cf = (r != 0);
        end
        fl = {dzf, zf, nf, cf, vf};
    endtask

    // Issue one request, optionally poke start mid-run, and check the result
    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int poke_at);
        logic [W-1:0] eq, er;
        logic [4:0]   ef;
        int cycles;
        model(sm, x, y, eq, er, ef);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; a = x; b = y;
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        while (!done && cycles < 100) begin
            if (cycles == poke_at) begin
                start = 1'b1; signed_mode = ~sm; a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(cycles), (y == 0) ? 32'd2 : 32'(W + 2));
        check({tag, ".busy_low"}, 32'(busy), 32'd0);
        check({tag, ".quotient"}, 32'(quotient), 32'(eq));
        check({tag, ".remainder"}, 32'(remainder), 32'(er));
        check({tag, ".flags"}, 32'({dz, Z, N, C, V}), 32'(ef));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".hold_q"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.q", 32'(quotient), 32'd0);
        check("reset.r", 32'(remainder), 32'd0);
        check("reset.flags", 32'({dz, Z, N, C, V}), 32'd0);
        rst = 1'b0;

        run_op("s100_7", 1'b1, 16'd100, 16'd7, -1);
        run_op("sm100_7", 1'b1, 16'hFF9C, 16'd7, -1);
        run_op("uffff_2", 1'b0, 16'hFFFF, 16'd2, -1);
        run_op("sffff_2", 1'b1, 16'hFFFF, 16'd2, -1);
        run_op("div0", 1'b0, 16'd1234, 16'd0, -1);
        run_op("sdiv0", 1'b1, 16'h8000, 16'd0, -1);
        run_op("ovf_poke", 1'b1, 16'h8000, 16'hFFFF, 6);
        run_op("u_max", 1'b0, 16'hFFFF, 16'hFFFF, -1);
        run_op("s_exact", 1'b1, 16'hFFF1, 16'hFFFB, 10);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] x, y;
            x = W'($urandom);
            y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 3) == 1 ? $urandom_range(1, 15) : $urandom);
            run_op($sformatf("rnd%0d", i), 1'($urandom), x, y, -1);
        end

        // Reset in the middle of an operation aborts it without a done
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 16'd5000; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.q", 32'(quotient), 32'd0);
        check("midrst.r", 32'(remainder), 32'd0);
        check("midrst.flags", 32'({done, dz, Z, N, C, V}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("midrst.no_done", 32'(seen), 32'd0);
        end
        run_op("after_rst", 1'b1, 16'hFC18, 16'd37, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
